// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lane_align.sv
// Byte-lane extraction/extension for loads and read-modify-write merge for stores.
// Purely combinational; no handshake of its own.
module lane_align
  import lsu_pkg::*;
#(
  parameter int width = 32
) (
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [1:0]       addr_lo,
  input  logic [width-1:0] mem_word,
  input  logic [width-1:0] store_data,
  output logic [width-1:0] load_data,
  output logic [width-1:0] merged_word
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // A misaligned halfword uses lane addr[1]; bit 0 plays no part in lane choice.
  assign byte_val = mem_word[{addr_lo, 3'b000} +: 8];
  assign half_val = mem_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = mem_word;
    case (size)
      SIZE_BYTE: load_data = {{(width-8){sign_ext & byte_val[7]}}, byte_val};
      SIZE_HALF: load_data = {{(width-16){sign_ext & half_val[15]}}, half_val};
      default:   load_data = mem_word;
    endcase
  end

  always_comb begin
    merged_word = mem_word;
    case (size)
      SIZE_BYTE: merged_word[{addr_lo, 3'b000} +: 8]     = store_data[7:0];
      SIZE_HALF: merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
      default:   merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit over a word-only memory; LSU_MISALIGN_TRAP_EN makes misaligned half/word accesses error.
// Latency: error 1, load/word store 2, sub-word store 3 cycles to resp_valid; req_ready only in IDLE.
// Backpressure: RESP holds indefinitely until resp_ready, with no memory activity meanwhile.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int addresswidth = 32,
  parameter int width        = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [addresswidth-1:0] req_address,
  input  logic [width-1:0]        req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [width-1:0]        resp_rdata,
  output logic                    resp_error,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_read_en,
  output logic                    mem_write_en,
  output logic [width-1:0]        mem_data_in,
  input  logic [width-1:0]        mem_data_out
);

  lsu_state_t              state;
  logic                    write_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [addresswidth-1:0] addr_q;
  logic [width-1:0]        wdata_q;
  logic [width-1:0]        rdata_q;
  logic                    error_q;
  logic [width-1:0]        word_q;

  logic                    misalign;
  logic                    req_error;
  logic [width-1:0]        load_data;
  logic [width-1:0]        merged_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SIZE_HALF) && req_address[0]) ||
                    ((req_size == SIZE_WORD) && (req_address[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_error = (req_size == SIZE_RSVD) || misalign;

  lane_align #(.width(width)) u_lane_align (
    .size        (size_q),
    .sign_ext    (signed_q),
    .addr_lo     (addr_q[1:0]),
    .mem_word    (mem_data_out),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      write_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
      word_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q  <= req_write;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_address;
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            error_q  <= req_error;
            if (req_error) begin
              state <= RESP;
            end else if (req_write && (req_size == SIZE_WORD)) begin
              word_q <= req_wdata;
              state  <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        // mem_data_out is only valid here; it is captured once and never sampled again.
        RD: begin
          if (write_q) begin
            word_q <= merged_word;
            state  <= WR;
          end else begin
            rdata_q <= load_data;
            state   <= RESP;
          end
        end
        WR: state <= RESP;
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes come straight from registered state so they are steady over the falling edge.
  assign req_ready    = (state == IDLE);
  assign resp_valid   = (state == RESP);
  assign resp_rdata   = resp_valid ? rdata_q : '0;
  assign resp_error   = resp_valid & error_q;
  assign mem_read_en  = (state == RD);
  assign mem_write_en = (state == WR);
  assign mem_data_in  = mem_write_en ? word_q : '0;
  assign mem_address  = {addr_q[addresswidth-1:2], 2'b00};

endmodule
